sim_timebase: RTL and testbench

SIM_TIMEBASE -- requirements
Module: sim_timebase

---
 rtl/sim_time_pkg.sv | 17 +
 rtl/tap_edge_detect.sv | 30 +++
 rtl/sim_timebase.sv | 117 +++++++++++
 tb/tb_sim_timebase.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_time_pkg.sv
// Shared definitions for the simulated-day timebase: FSM states, default
// day geometry and counter widths.
package sim_time_pkg;

    localparam int TICKS_PER_HOUR_DEF = 4;
    localparam int DAY_HOURS_DEF      = 8;
    localparam int SUB_TICK_W         = 8;
    localparam int HOUR_W             = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } sim_state_e;

endpackage

// File: rtl/tap_edge_detect.sv
// Rising-edge detector on a selectable bit of the upstream divider count.
// A change of the tap index blanks the edge for that cycle, so switching
// taps can never manufacture a spurious edge from two unrelated bits.
module tap_edge_detect (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] divided_clocks,
    input  logic [4:0]  tap_sel,
    output logic        edge_det
);

    logic       sel_bit;
    logic       prev_bit;
    logic [4:0] tap_q;

    assign sel_bit  = divided_clocks[tap_sel];
    assign edge_det = sel_bit && !prev_bit && (tap_sel == tap_q);

    // Remember the previous selected bit and tap index every cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_bit <= 1'b0;
            tap_q    <= 5'd0;
        end else begin
            prev_bit <= sel_bit;
            tap_q    <= tap_sel;
        end
    end

endmodule

// File: rtl/sim_timebase.sv
// Simulated-day timebase: counts time-base edges into sub-ticks and hours,
// runs one day and stops in DONE until restarted.
// Optional feature macro: SIM_TIMEBASE_HOUR_PULSE_EN adds a hour_pulse
// output that fires with the tick that completes each hour.
// Handshake: start and pause are plain levels sampled every rising edge;
// there is no ready/ack, start is only honoured in IDLE or DONE.
module sim_timebase
    import sim_time_pkg::*;
#(
    parameter int TICKS_PER_HOUR = TICKS_PER_HOUR_DEF,
    parameter int DAY_HOURS      = DAY_HOURS_DEF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [31:0]           divided_clocks,
    input  logic [4:0]            tap_sel,
    input  logic                  start,
    input  logic                  pause,
    output logic                  tick,
    output logic [SUB_TICK_W-1:0] sub_tick,
    output logic [HOUR_W-1:0]     hour,
    output logic                  running,
    output logic                  day_done,
`ifdef SIM_TIMEBASE_HOUR_PULSE_EN
    output logic                  hour_pulse,
`endif
    output sim_state_e            state_dbg
);

    localparam logic [SUB_TICK_W-1:0] SUB_LAST  = SUB_TICK_W'(TICKS_PER_HOUR - 1);
    localparam logic [HOUR_W-1:0]     HOUR_LAST = HOUR_W'(DAY_HOURS - 1);

    sim_state_e            state, state_n;
    logic [SUB_TICK_W-1:0] sub_n;
    logic [HOUR_W-1:0]     hour_n;
    logic                  tick_n;
    logic                  edge_det;

    tap_edge_detect u_edge (
        .clock          (clock),
        .reset_n        (reset_n),
        .divided_clocks (divided_clocks),
        .tap_sel        (tap_sel),
        .edge_det       (edge_det)
    );

    // State, counters and the registered tick pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            sub_tick <= '0;
            hour     <= '0;
            tick     <= 1'b0;
        end else begin
            state    <= state_n;
            sub_tick <= sub_n;
            hour     <= hour_n;
            tick     <= tick_n;
        end
    end

    // Next-state and counter advance; an edge only counts in RUN without pause.
    always_comb begin
        state_n = state;
        sub_n   = sub_tick;
        hour_n  = hour;
        tick_n  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n = ST_RUN;
                    sub_n   = '0;
                    hour_n  = '0;
                end
            end
            ST_RUN: begin
                if (pause) begin
                    state_n = ST_PAUSE;
                end else if (edge_det) begin
                    tick_n = 1'b1;
                    if (sub_tick == SUB_LAST) begin
                        sub_n = '0;
                        if (hour == HOUR_LAST) begin
                            state_n = ST_DONE;
                        end else begin
                            hour_n = hour + 1'b1;
                        end
                    end else begin
                        sub_n = sub_tick + 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (!pause) begin
                    state_n = ST_RUN;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign running   = (state == ST_RUN);
    assign day_done  = (state == ST_DONE);
    assign state_dbg = state;

`ifdef SIM_TIMEBASE_HOUR_PULSE_EN
    // Pulse alongside the tick that wraps sub_tick (hour step or end of day).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hour_pulse <= 1'b0;
        end else begin
            hour_pulse <= tick_n && (sub_tick == SUB_LAST);
        end
    end
`endif

endmodule

// File: tb/tb_sim_timebase.sv
// Bench for sim_timebase: directed day/pause/tap/reset scenarios followed
// by randomized traffic, all checked against a tick-count model of the day.
module tb_sim_timebase;
    import sim_time_pkg::*;

    localparam int TPH   = 4;
    localparam int DH    = 8;
    localparam int TOTAL = TPH * DH;

    // clock / reset
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic [31:0] divided_clocks;
    logic [4:0]  tap_sel;
    logic        start;
    logic        pause;
    logic        tick;
    logic [7:0]  sub_tick;
    logic [3:0]  hour;
    logic        running;
    logic        day_done;
`ifdef SIM_TIMEBASE_HOUR_PULSE_EN
    logic        hour_pulse;
`endif
    sim_state_e  state_dbg;

    sim_timebase #(.TICKS_PER_HOUR(TPH), .DAY_HOURS(DH)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .divided_clocks (divided_clocks),
        .tap_sel        (tap_sel),
        .start          (start),
        .pause          (pause),
        .tick           (tick),
        .sub_tick       (sub_tick),
        .hour           (hour),
        .running        (running),
        .day_done       (day_done),
`ifdef SIM_TIMEBASE_HOUR_PULSE_EN
        .hour_pulse     (hour_pulse),
`endif
        .state_dbg      (state_dbg)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reference model: the day is just a count of accepted edges.
    sim_state_e  m_state;
    int          m_count;
    logic        m_tick;
    logic        m_hp;
    logic        m_prev_sel;
    logic [4:0]  m_prev_tap;
    logic        last_tick;
    logic [31:0] dc_cnt;
    logic [11:0] exp_q[$];

    function automatic int exp_sub();
        return m_count % TPH;
    endfunction

    function automatic int exp_hour();
        return (m_count / TPH > DH - 1) ? DH - 1 : m_count / TPH;
    endfunction

    task automatic model_reset();
        m_state    = ST_IDLE;
        m_count    = 0;
        m_tick     = 1'b0;
        m_hp       = 1'b0;
        m_prev_sel = 1'b0;
        m_prev_tap = 5'd0;
        last_tick  = 1'b0;
    endtask

    task automatic model_step(input logic [31:0] dc, input logic [4:0] tp, input logic st, input logic pz);
        logic sel;
        logic ed;
        sel    = dc[tp];
        ed     = sel && !m_prev_sel && (tp == m_prev_tap);
        m_tick = 1'b0;
        m_hp   = 1'b0;
        case (m_state)
            ST_IDLE, ST_DONE: if (st) begin
                m_state = ST_RUN;
                m_count = 0;
            end
            ST_RUN: begin
                if (pz) begin
                    m_state = ST_PAUSE;
                end else if (ed) begin
                    m_tick  = 1'b1;
                    m_count = m_count + 1;
                    if (m_count % TPH == 0) m_hp = 1'b1;
                    if (m_count == TOTAL) m_state = ST_DONE;
                    exp_q.push_back({4'(exp_hour()), 8'(exp_sub())});
                end
            end
            ST_PAUSE: if (!pz) m_state = ST_RUN;
            default: m_state = ST_IDLE;
        endcase
        m_prev_sel = sel;
        m_prev_tap = tp;
    endtask

    // Scoreboard: every cycle against the model, every tick against exp_q.
    task automatic compare_outputs();
        logic [11:0] exp_pos;
        check_eq("tick", tick, m_tick);
        check_eq("sub_tick", sub_tick, exp_sub());
        check_eq("hour", hour, exp_hour());
        check_eq("running", running, m_state == ST_RUN);
        check_eq("day_done", day_done, m_state == ST_DONE);
        check_eq("state", 32'(state_dbg), 32'(m_state));
        check_eq("tick_double", tick & last_tick, 0);
`ifdef SIM_TIMEBASE_HOUR_PULSE_EN
        check_eq("hour_pulse", hour_pulse, m_hp);
`endif
        if (tick) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_tick", 1, 0);
            end else begin
                exp_pos = exp_q.pop_front();
                check_eq("sb_tick_pos", {hour, sub_tick}, exp_pos);
            end
        end
        last_tick = tick;
    endtask

    // driver: one clock cycle with the given levels
    task automatic step(input logic st, input logic pz, input logic [4:0] tp);
        @(negedge clock);
        reset_n        = 1'b1;
        start          = st;
        pause          = pz;
        tap_sel        = tp;
        dc_cnt         = dc_cnt + 1;
        divided_clocks = dc_cnt;
        model_step(divided_clocks, tp, st, pz);
        @(posedge clock);
        #1;
        compare_outputs();
    endtask

    // driver: assert reset mid-cycle; released by the next step()
    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_eq("rst_tick", tick, 0);
        check_eq("rst_sub_tick", sub_tick, 0);
        check_eq("rst_hour", hour, 0);
        check_eq("rst_running", running, 0);
        check_eq("rst_day_done", day_done, 0);
        check_eq("rst_state", 32'(state_dbg), 32'(ST_IDLE));
`ifdef SIM_TIMEBASE_HOUR_PULSE_EN
        check_eq("rst_hour_pulse", hour_pulse, 0);
`endif
        check_eq("sb_left_at_reset", exp_q.size(), 0);
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
    endtask

    int ticks;
    int hour1_at;
    int last_tick_cyc;
    int hp_cnt;
    int cyc;
    logic [7:0] saved_sub;
    logic [3:0] saved_hour;
    logic       st_r, pz_r;
    logic [4:0] tp_r;

    initial begin
        reset_n        = 1'b0;
        start          = 1'b0;
        pause          = 1'b0;
        tap_sel        = 5'd0;
        dc_cnt         = 32'd0;
        divided_clocks = 32'd0;
        model_reset();
        apply_reset();

        // Full day on tap 0: tick every 2nd cycle, hour 1 after 4 ticks.
        step(1'b1, 1'b0, 5'd0);
        ticks = 0; hour1_at = -1; last_tick_cyc = -1; hp_cnt = 0;
        for (int i = 0; i < 200 && !day_done; i++) begin
            step(1'b0, 1'b0, 5'd0);
            if (tick) begin
                ticks++;
                if (last_tick_cyc >= 0) check_eq("tick_period", i - last_tick_cyc, 2);
                last_tick_cyc = i;
            end
`ifdef SIM_TIMEBASE_HOUR_PULSE_EN
            if (hour_pulse) hp_cnt++;
`endif
            if (hour == 4'd1 && hour1_at < 0) hour1_at = ticks;
        end
        check_eq("day_reached_done", day_done, 1);
        check_eq("day_tick_total", ticks, TOTAL);
        check_eq("hour1_after_ticks", hour1_at, TPH);
        check_eq("done_hour", hour, DH - 1);
        check_eq("done_sub", sub_tick, 0);
`ifdef SIM_TIMEBASE_HOUR_PULSE_EN
        check_eq("hour_pulse_count", hp_cnt, DH);
`endif

        // DONE with start and pause together: one RUN cycle, then PAUSE.
        step(1'b0, 1'b0, 5'd0);
        step(1'b1, 1'b1, 5'd0);
        check_eq("restart_running", running, 1);
        check_eq("restart_sub", sub_tick, 0);
        check_eq("restart_hour", hour, 0);
        step(1'b0, 1'b1, 5'd0);
        check_eq("restart_paused", 32'(state_dbg), 32'(ST_PAUSE));

        // Tap 3, pause for 40 cycles mid-hour.
        for (int i = 0; i < 100 && sub_tick != 8'd2; i++) step(1'b0, 1'b0, 5'd3);
        check_eq("tap3_reached_sub2", sub_tick, 2);
        saved_sub  = sub_tick;
        saved_hour = hour;
        repeat (40) begin
            step(1'b0, 1'b1, 5'd3);
            check_eq("pause_tick", tick, 0);
            check_eq("pause_sub_frozen", sub_tick, saved_sub);
            check_eq("pause_hour_frozen", hour, saved_hour);
        end
        for (int i = 0; i < 40 && !tick; i++) step(1'b0, 1'b0, 5'd3);
        check_eq("resume_tick", tick, 1);
        check_eq("resume_sub", sub_tick, saved_sub + 8'd1);

        // Tap change 2 -> 0 where new bit is 1 and prior bit was 0.
        for (int i = 0; i < 16 && !(dc_cnt[2] == 1'b0 && dc_cnt[0] == 1'b0); i++)
            step(1'b0, 1'b0, 5'd2);
        step(1'b0, 1'b0, 5'd2);
        for (int i = 0; i < 16 && !(dc_cnt[2] == 1'b0 && dc_cnt[0] == 1'b0); i++)
            step(1'b0, 1'b0, 5'd2);
        check_eq("tapchg_running", running, 1);
        step(1'b0, 1'b0, 5'd0);
        check_eq("tapchg_no_tick", tick, 0);

        // Reset at hour 5, then idle until start.
        for (int i = 0; i < 100 && hour != 4'd5; i++) step(1'b0, 1'b0, 5'd0);
        check_eq("reached_hour5", hour, 5);
        apply_reset();
        repeat (10) begin
            step(1'b0, 1'b0, 5'd0);
            check_eq("post_rst_no_tick", tick, 0);
        end

        // Randomized traffic.
        st_r = 1'b0; pz_r = 1'b0; tp_r = 5'd0;
        for (cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 399) == 0) apply_reset();
            if ($urandom_range(0, 19) == 0) tp_r = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) pz_r = ~pz_r;
            st_r = ($urandom_range(0, 15) == 0);
            step(st_r, pz_r, tp_r);
        end
        check_eq("sb_left_at_end", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
